// File: rtl/vdma_rd_frame_sched.sv
// Read-side frame scheduler: selects the next frame buffer, handshakes it to the read DMA,
// and holds the output sync generator off until the output FIFO has been primed.
module vdma_rd_frame_sched #(
  parameter int NBUF      = 3,
  parameter int BUF_W     = 2,
  parameter int PRIME_CYC = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wr_frame_done,
  input  logic [BUF_W-1:0] wr_buf_idx,
  output logic             rd_req,
  output logic [BUF_W-1:0] rd_buf_idx,
  input  logic             rd_ack,
  input  logic             fifo_empty,
  input  logic             rd_en,
  input  logic             falign,
  input  logic             ealign,
  output logic             enable_inner_sync,
  output logic             busy,
  output logic             underflow,
  output logic [15:0]      underflow_cnt,
  output logic [15:0]      repeat_cnt,
  output logic [15:0]      frame_cnt
);

  // state | meaning
  // IDLE  | stopped, waiting for enable and a completed frame
  // REQ   | first frame of the run requested, waiting for the DMA ack
  // PRIME | counting consecutive non-empty FIFO cycles
  // RUN   | sync running, a new frame requested at every ealign
  // DRAIN | finishing the current frame before returning to IDLE
  typedef enum logic [2:0] {IDLE, REQ, PRIME, RUN, DRAIN} state_t;

  localparam logic [BUF_W:0] NBUF_V     = (BUF_W+1)'(NBUF);
  localparam logic [7:0]     PRIME_LAST = 8'(PRIME_CYC - 1);

  state_t           state, state_nxt;
  logic             have_new;
  logic [BUF_W-1:0] last_done;
  logic [7:0]       prime_cnt;
  logic             defer;
  logic             drain_fast;
  logic             ealign_seen;
  logic             wr_valid;
  logic             launch;
  logic [BUF_W-1:0] sel_idx;
  logic             sel_repeat;

  assign wr_valid   = wr_frame_done && ({1'b0, wr_buf_idx} < NBUF_V);
  assign sel_idx    = wr_valid ? wr_buf_idx : (have_new ? last_done : rd_buf_idx);
  assign sel_repeat = !wr_valid && !have_new;

  assign busy              = (state != IDLE);
  assign enable_inner_sync = (state == RUN) || (state == DRAIN && !drain_fast && !ealign_seen);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && have_new) begin
          state_nxt = REQ;
          launch    = 1'b1;
        end
      end
      REQ: if (rd_ack) state_nxt = PRIME;
      PRIME: begin
        if (!enable) state_nxt = DRAIN;
        else if (!fifo_empty && prime_cnt == PRIME_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) state_nxt = DRAIN;
        else if ((ealign || defer) && !rd_req) launch = 1'b1;
      end
      DRAIN: if ((drain_fast || ealign_seen || ealign) && !rd_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      have_new      <= 1'b0;
      last_done     <= '0;
      rd_req        <= 1'b0;
      rd_buf_idx    <= '0;
      prime_cnt     <= '0;
      defer         <= 1'b0;
      drain_fast    <= 1'b0;
      ealign_seen   <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
      repeat_cnt    <= '0;
      frame_cnt     <= '0;
    end else begin
      if (wr_valid) last_done <= wr_buf_idx;
      // a same-cycle write is always the one consumed by the bypass
      if (launch)        have_new <= 1'b0;
      else if (wr_valid) have_new <= 1'b1;

      if (launch) begin
        rd_req     <= 1'b1;
        rd_buf_idx <= sel_idx;
        if (sel_repeat && repeat_cnt != 16'hFFFF) repeat_cnt <= repeat_cnt + 16'd1;
      end else if (rd_req && rd_ack) begin
        rd_req <= 1'b0;
      end

      if (state == REQ)        prime_cnt <= '0;
      else if (state == PRIME) prime_cnt <= fifo_empty ? 8'd0 : prime_cnt + 8'd1;

      defer       <= (state_nxt == RUN) && !launch && (defer || (ealign && rd_req));
      drain_fast  <= (state_nxt == DRAIN) && ((state == PRIME) || drain_fast);
      ealign_seen <= (state_nxt == DRAIN) && (state == DRAIN) && (ealign_seen || ealign);

      if (state == RUN && falign) frame_cnt <= frame_cnt + 16'd1;

      if (rd_en && fifo_empty) begin
        underflow <= 1'b1;
        if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      end else if (state == IDLE && state_nxt == REQ) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vdma_rd_frame_sched.sv
// Bench for vdma_rd_frame_sched: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the scheduler.
module tb_vdma_rd_frame_sched;
  localparam int NBUF = 3, BUF_W = 2, PRIME_CYC = 16;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             enable, wr_frame_done, rd_ack, fifo_empty, rd_en, falign, ealign;
  logic [BUF_W-1:0] wr_buf_idx;
  logic             rd_req, enable_inner_sync, busy, underflow;
  logic [BUF_W-1:0] rd_buf_idx;
  logic [15:0]      underflow_cnt, repeat_cnt, frame_cnt;

  always #5 clock = ~clock;

  vdma_rd_frame_sched #(.NBUF(NBUF), .BUF_W(BUF_W), .PRIME_CYC(PRIME_CYC)) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .wr_frame_done(wr_frame_done),
    .wr_buf_idx(wr_buf_idx), .rd_req(rd_req), .rd_buf_idx(rd_buf_idx), .rd_ack(rd_ack),
    .fifo_empty(fifo_empty), .rd_en(rd_en), .falign(falign), .ealign(ealign),
    .enable_inner_sync(enable_inner_sync), .busy(busy), .underflow(underflow),
    .underflow_cnt(underflow_cnt), .repeat_cnt(repeat_cnt), .frame_cnt(frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase of the run plus the bookkeeping the scheduler is expected to keep.
  localparam int P_IDLE = 0, P_WAIT = 1, P_FILL = 2, P_SHOW = 3, P_STOP = 4;
  int m_phase, m_latest, m_idx, m_fill, m_ucnt, m_rcnt, m_fcnt;
  bit m_fresh, m_req, m_owed, m_quick, m_ended, m_uf;

  function automatic void model_reset();
    m_phase = P_IDLE; m_latest = 0; m_idx = 0; m_fill = 0;
    m_ucnt = 0; m_rcnt = 0; m_fcnt = 0;
    m_fresh = 0; m_req = 0; m_owed = 0; m_quick = 0; m_ended = 0; m_uf = 0;
  endfunction

  function automatic void model_step();
    bit wv, go, old_req;
    int nphase;
    wv      = wr_frame_done && (int'(wr_buf_idx) < NBUF);
    go      = 0;
    old_req = m_req;
    nphase  = m_phase;
    if (m_phase == P_IDLE && enable && m_fresh) begin go = 1; nphase = P_WAIT; end
    if (m_phase == P_WAIT && rd_ack) nphase = P_FILL;
    if (m_phase == P_FILL) begin
      if (!enable) nphase = P_STOP;
      else if (!fifo_empty && m_fill + 1 >= PRIME_CYC) nphase = P_SHOW;
    end
    if (m_phase == P_SHOW) begin
      if (!enable) nphase = P_STOP;
      else if ((ealign || m_owed) && !old_req) go = 1;
    end
    if (m_phase == P_STOP && (m_quick || m_ended || ealign) && !old_req) nphase = P_IDLE;

    if (go) begin
      if (wv)           m_idx = int'(wr_buf_idx);
      else if (m_fresh) m_idx = m_latest;
      else if (m_rcnt < 65535) m_rcnt++;
      m_req = 1;
    end else if (old_req && rd_ack) begin
      m_req = 0;
    end

    m_owed  = (nphase == P_SHOW) && !go && (m_owed || (ealign && old_req));
    m_ended = (m_phase == P_STOP) && (nphase == P_STOP) && (m_ended || ealign);
    m_quick = (nphase == P_STOP) && (m_phase == P_FILL || m_quick);

    if (m_phase == P_WAIT)      m_fill = 0;
    else if (m_phase == P_FILL) m_fill = fifo_empty ? 0 : m_fill + 1;

    if (go)      m_fresh = 0;
    else if (wv) m_fresh = 1;
    if (wv) m_latest = int'(wr_buf_idx);

    if (m_phase == P_SHOW && falign) m_fcnt = (m_fcnt + 1) % 65536;
    if (m_phase == P_IDLE && nphase == P_WAIT) m_uf = 0;
    if (rd_en && fifo_empty) begin
      m_uf = 1;
      if (m_ucnt < 65535) m_ucnt++;
    end
    m_phase = nphase;
  endfunction

  task automatic check_all();
    bit exp_sync;
    exp_sync = (m_phase == P_SHOW) || (m_phase == P_STOP && !m_quick && !m_ended);
    check_val("rd_req",            32'(rd_req),            32'(m_req));
    check_val("rd_buf_idx",        32'(rd_buf_idx),        32'(m_idx));
    check_val("busy",              32'(busy),              32'(m_phase != P_IDLE));
    check_val("enable_inner_sync", 32'(enable_inner_sync), 32'(exp_sync));
    check_val("underflow",         32'(underflow),         32'(m_uf));
    check_val("underflow_cnt",     32'(underflow_cnt),     32'(m_ucnt));
    check_val("repeat_cnt",        32'(repeat_cnt),        32'(m_rcnt));
    check_val("frame_cnt",         32'(frame_cnt),         32'(m_fcnt));
  endtask

  // Called at a negedge: apply inputs, advance one clock, then check at the next negedge.
  task automatic cycle(input logic en, input logic wfd, input logic [BUF_W-1:0] widx,
                       input logic ack, input logic fe, input logic ren,
                       input logic fa, input logic ea);
    enable = en; wr_frame_done = wfd; wr_buf_idx = widx; rd_ack = ack;
    fifo_empty = fe; rd_en = ren; falign = fa; ealign = ea;
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int   hi, sync_at;
    logic en_r;
    rst_n = 1'b0;
    enable = 0; wr_frame_done = 0; wr_buf_idx = '0; rd_ack = 0;
    fifo_empty = 1; rd_en = 0; falign = 0; ealign = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    rst_n = 1'b1;

    repeat (5) cycle(1, 0, 0, 0, 1, 0, 0, 0);
    check_val("idle_busy", 32'(busy), 0);
    check_val("idle_req", 32'(rd_req), 0);

    cycle(1, 1, 2, 0, 1, 0, 0, 0);
    hi = 0;
    cycle(1, 0, 0, 0, 1, 0, 0, 0);
    hi += int'(rd_req);
    check_val("first_idx", 32'(rd_buf_idx), 2);
    repeat (3) begin
      cycle(1, 0, 0, 0, 1, 0, 0, 0);
      hi += int'(rd_req);
    end
    cycle(1, 0, 0, 1, 0, 0, 0, 0);
    hi += int'(rd_req);
    check_val("req_high_cycles", 32'(hi), 4);

    sync_at = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      if (sync_at == 0 && enable_inner_sync) sync_at = k + 1;
    end
    check_val("sync_start_cycle", 32'(sync_at), PRIME_CYC + 1);

    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    check_val("newest_idx", 32'(rd_buf_idx), 1);
    check_val("no_repeat", 32'(repeat_cnt), 0);
    check_val("one_pixel_frame", 32'(frame_cnt), 1);
    cycle(1, 0, 0, 1, 0, 0, 0, 0);

    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    check_val("repeat_idx", 32'(rd_buf_idx), 1);
    check_val("repeat_one", 32'(repeat_cnt), 1);
    cycle(1, 0, 0, 1, 0, 0, 0, 0);

    cycle(1, 1, 0, 0, 0, 0, 0, 1);
    check_val("bypass_idx", 32'(rd_buf_idx), 0);
    cycle(1, 0, 0, 1, 0, 0, 0, 0);

    repeat (3) cycle(1, 0, 0, 0, 1, 1, 0, 0);
    check_val("underflow_flag", 32'(underflow), 1);
    check_val("underflow_three", 32'(underflow_cnt), 3);

    cycle(1, 1, 3, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    check_val("bad_idx_ignored", 32'(rd_buf_idx), 0);
    check_val("repeat_two", 32'(repeat_cnt), 2);
    cycle(1, 0, 0, 1, 0, 0, 0, 0);

    repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check_val("drain_sync_held", 32'(enable_inner_sync), 1);
    check_val("drain_busy", 32'(busy), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check_val("drain_sync_off", 32'(enable_inner_sync), 0);
    check_val("drain_idle", 32'(busy), 0);

    en_r = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 149) == 0) en_r = !en_r;
      if (c % 700 == 350) async_reset();
      cycle(en_r,
            1'($urandom_range(0, 11) == 0),
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 29) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vdma_rd_frame_sched.md
Name: vdma_rd_frame_sched

Overview:
- Read-side frame scheduler for the VDMA output path.
- Picks which frame buffer the read DMA fetches next and issues a per-frame request/ack handshake to the read DMA.
- Gates the output port's internal sync generator (drives its enable_inner_sync) so timing starts only after the FIFO is primed.
- Monitors the output port's frame alignment pulses and counts underflows; sits between the write-side buffer manager, the read DMA and the output port.

Parameters:
- NBUF, 3, number of frame buffers (2..4).
- BUF_W, 2, index width; must satisfy 2^BUF_W >= NBUF.
- PRIME_CYC, 16, cycles the FIFO must be continuously non-empty before sync starts (1..255).

Ports:
- clock  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; run request from the register block.
- wr_frame_done  in  1  pulse; write side finished a frame.
- wr_buf_idx  in  BUF_W  buffer just completed; valid with wr_frame_done.
- rd_req  out  1  frame fetch request to the read DMA.
- rd_buf_idx  out  BUF_W  buffer to fetch; stable while rd_req=1.
- rd_ack  in  1  DMA accepts the request.
- fifo_empty  in  1  output FIFO empty.
- rd_en  in  1  output port pops the FIFO.
- falign  in  1  pulse; first pixel of a frame.
- ealign  in  1  pulse; last pixel of a frame.
- enable_inner_sync  out  1  sync generator run enable.
- busy  out  1  state != IDLE.
- underflow  out  1  sticky; rd_en while fifo_empty.
- underflow_cnt  out  16  saturating underflow count.
- repeat_cnt  out  16  saturating count of frames re-sent with no new write.
- frame_cnt  out  16  wrapping count of falign pulses seen in RUN.

Behaviour:
- Reset values: all outputs 0; state=IDLE; have_new=0; last_done=0.
- Write tracking:
  - wr_frame_done with wr_buf_idx < NBUF: last_done <= wr_buf_idx, have_new <= 1.
  - Index >= NBUF: pulse is ignored.
- Selection function SEL, evaluated when a request is launched:
  - If a valid wr_frame_done occurs in the same cycle, use its wr_buf_idx (bypass).
  - Else if have_new=1, use last_done.
  - Else repeat the current rd_buf_idx and increment repeat_cnt (not on the first request of a run).
  - have_new clears at launch unless a new valid wr_frame_done arrives that same cycle and was not the one consumed.
- Handshake:
  - rd_req rises with rd_buf_idx loaded, on the same clock edge.
  - rd_req holds until the cycle where rd_req & rd_ack; it drops on the next edge.
  - rd_ack while rd_req=0 is ignored.
  - At most one outstanding request.
- FSM:
  - IDLE: enable_inner_sync=0. On enable & have_new -> REQ; rd_req launched on the same edge.
  - REQ: on rd_ack -> PRIME; prime counter cleared.
  - PRIME:
    - Counter increments while !fifo_empty and clears when fifo_empty.
    - At PRIME_CYC -> RUN; enable_inner_sync=1 from the next cycle.
    - enable=0 -> DRAIN.
  - RUN:
    - enable_inner_sync=1.
    - On ealign, launch the next request via SEL.
    - If the previous request is still pending at ealign, launch is deferred to the ack cycle +1; repeat_cnt is not incremented for the deferral.
    - enable=0 -> DRAIN.
  - DRAIN:
    - enable_inner_sync stays 1 until ealign, then 0 -> IDLE.
    - No new requests are launched.
    - An outstanding rd_req still completes its handshake; IDLE is entered only when ealign has been seen and rd_req=0.
    - Entered from PRIME, it goes straight to IDLE once rd_req=0.
- Counters:
  - frame_cnt++ on falign in RUN.
  - rd_en & fifo_empty: underflow <= 1 and underflow_cnt++ (saturates at 0xFFFF), in any state.
  - underflow is cleared only by reset or IDLE->REQ.
- Simultaneous events:
  - ealign & wr_frame_done: bypass index is used.
  - falign & ealign in the same cycle (1-pixel frame): both are honoured.
- Asynchronous reset mid-frame: every register returns to its reset value immediately; rd_req drops without an ack.

Test Plan:
- Reset, enable=1, no writes -> stays IDLE; rd_req=0, busy=0.
- wr_frame_done idx=2; ack after 3 cycles; FIFO non-empty 16 cycles -> rd_req high with idx 2 for 4 cycles; enable_inner_sync=1 at PRIME_CYC+1.
- In RUN, writes idx 0 then 1 before ealign -> next request idx=1, repeat_cnt=0.
- No write between two ealign -> second request repeats the previous idx; repeat_cnt=1.
- ealign and wr_frame_done idx=0 in the same cycle -> rd_buf_idx=0.
- enable=0 mid-frame -> enable_inner_sync stays high until ealign, then IDLE.
- rd_en with fifo_empty for 3 cycles -> underflow=1, underflow_cnt=3.
- wr_buf_idx=3 with NBUF=3 -> pulse ignored, have_new unchanged.
